// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//    Sequential packed-BCD to unsigned binary converter. Digits are consumed
//    most-significant first, one per clock: acc = acc*10 + digit.
//    Handshake: start (sampled when not busy) -> busy -> one-cycle done.
//
// Parameters
//    DIGITS  number of BCD digits in bcd_in (1..8)
//    BIN_W   width of bin_out (2^BIN_W must exceed 10^DIGITS-1 for exact results)
//
// Ports
//    clk      rising-edge clock
//    reset    asynchronous active-high reset
//    start    conversion request, ignored while busy
//    bcd_in   packed BCD operand, [3:0] = units digit
//    busy     conversion in progress
//    done     one-cycle pulse, bin_out/err valid
//    bin_out  binary result, held until the next done
//    err      operand contained a digit > 9 (error-check build only)
//
// Optional feature
//    BCD_TO_BIN_ERRCHK_EN  when defined, non-BCD digits set err and force
//                          bin_out to 0; otherwise err is tied low and
//                          digits 10..15 accumulate with their raw value.

module bcd_to_bin_seq #(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST = 4'(DIGITS - 1);

   state_t                state;
   logic [4*DIGITS-1:0]   shreg;
   logic [BIN_W-1:0]      acc;
   logic [3:0]            cnt;

   logic [3:0]            digit;
   logic [BIN_W-1:0]      acc_next;

`ifdef BCD_TO_BIN_ERRCHK_EN
   logic                  err_flag;
   logic                  err_flag_next;
`endif

   // acc*10 as (acc<<3)+(acc<<1), truncated to BIN_W (wraps if BIN_W too small)
   always_comb begin
      digit    = shreg[4*DIGITS-1 -: 4];
      acc_next = (acc << 3) + (acc << 1) + BIN_W'(digit);
`ifdef BCD_TO_BIN_ERRCHK_EN
      err_flag_next = err_flag | (digit > 4'd9);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bin_out  <= '0;
`ifdef BCD_TO_BIN_ERRCHK_EN
         err_flag <= 1'b0;
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg    <= bcd_in;
                  acc      <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
`ifdef BCD_TO_BIN_ERRCHK_EN
                  err_flag <= 1'b0;
`endif
                  state    <= CONV;
               end
            end

            CONV: begin
               acc   <= acc_next;
               shreg <= shreg << 4;
               cnt   <= cnt + 4'd1;
`ifdef BCD_TO_BIN_ERRCHK_EN
               err_flag <= err_flag_next;
`endif
               // Result is taken from the combinational next value so the
               // last digit lands in bin_out on the same edge that enters DONE.
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef BCD_TO_BIN_ERRCHK_EN
                  bin_out <= err_flag_next ? '0 : acc_next;
                  err     <= err_flag_next;
`else
                  bin_out <= acc_next;
`endif
                  state <= DONE;
               end
            end

            DONE: begin
               done <= 1'b0;
               if (start) begin
                  shreg    <= bcd_in;
                  acc      <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
`ifdef BCD_TO_BIN_ERRCHK_EN
                  err_flag <= 1'b0;
`endif
                  state    <= CONV;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

`ifndef BCD_TO_BIN_ERRCHK_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

   logic        clk;
   logic        reset;

   logic        start0;
   logic [7:0]  bcd0;
   logic        busy0, done0, err0;
   logic [6:0]  bin0;

   logic        start1;
   logic [11:0] bcd1;
   logic        busy1, done1, err1;
   logic [9:0]  bin1;

   int checks;
   int errors;

   bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) u0 (
      .clk(clk), .reset(reset), .start(start0), .bcd_in(bcd0),
      .busy(busy0), .done(done0), .bin_out(bin0), .err(err0)
   );

   bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) u1 (
      .clk(clk), .reset(reset), .start(start1), .bcd_in(bcd1),
      .busy(busy1), .done(done1), .bin_out(bin1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || bin0 !== 7'd0 || err0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_u0 busy=%b done=%b bin=%0d err=%b expected 0 0 0 0", busy0, done0, bin0, err0);
      end
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || bin1 !== 10'd0 || err1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_u1 busy=%b done=%b bin=%0d err=%b expected 0 0 0 0", busy1, done1, bin1, err1);
      end
      #2 reset = 1'b0;
      cyc();
   endtask

   task automatic test_basic();
      bcd0 = 8'h99; start0 = 1'b1;
      cyc();                       // edge T
      start0 = 1'b0;
      checks++;
      if (busy0 !== 1'b1 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_T1 busy=%b done=%b expected 1 0", busy0, done0);
      end
      cyc();                       // edge T+1
      checks++;
      if (busy0 !== 1'b1 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_T2 busy=%b done=%b expected 1 0", busy0, done0);
      end
      cyc();                       // edge T+2: done cycle
      checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b0 || bin0 !== 7'd99 || err0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_done done=%b busy=%b bin=%0d err=%b expected 1 0 99 0", done0, busy0, bin0, err0);
      end
      cyc();
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || bin0 !== 7'd99) begin
         errors++;
         $display("FAIL basic_hold done=%b busy=%b bin=%0d expected 0 0 99", done0, busy0, bin0);
      end
   endtask

   task automatic test_back_to_back();
      bcd0 = 8'h00; start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      cyc();
      cyc();
      checks++;
      if (done0 !== 1'b1 || bin0 !== 7'd0) begin
         errors++;
         $display("FAIL b2b_first done=%b bin=%0d expected 1 0", done0, bin0);
      end
      bcd0 = 8'h57; start0 = 1'b1;   // start during the DONE cycle
      cyc();
      start0 = 1'b0;
      bcd0 = 8'h88;                  // must not affect the latched operand
      checks++;
      if (busy0 !== 1'b1 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept busy=%b done=%b expected 1 0", busy0, done0);
      end
      cyc();
      checks++;
      if (done0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_early done=%b expected 0", done0);
      end
      cyc();
      checks++;
      if (done0 !== 1'b1 || bin0 !== 7'd57 || err0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second done=%b bin=%0d err=%b expected 1 57 0", done0, bin0, err0);
      end
      cyc();
   endtask

   task automatic test_start_while_busy();
      bcd0 = 8'h42; start0 = 1'b1;
      cyc();
      bcd0 = 8'h11;                  // start stays high while busy
      cyc();
      cyc();
      start0 = 1'b0;
      checks++;
      if (done0 !== 1'b1 || bin0 !== 7'd42) begin
         errors++;
         $display("FAIL busy_ignore done=%b bin=%0d expected 1 42", done0, bin0);
      end
      cyc();
      cyc();
      cyc();
      cyc();
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || bin0 !== 7'd42) begin
         errors++;
         $display("FAIL busy_extra done=%b busy=%b bin=%0d expected 0 0 42", done0, busy0, bin0);
      end
   endtask

   task automatic test_err();
      bcd0 = 8'h4A; start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      cyc();
      cyc();
      checks++;
`ifdef BCD_TO_BIN_ERRCHK_EN
      if (done0 !== 1'b1 || bin0 !== 7'd0 || err0 !== 1'b1) begin
         errors++;
         $display("FAIL err_4A done=%b bin=%0d err=%b expected 1 0 1", done0, bin0, err0);
      end
`else
      if (done0 !== 1'b1 || bin0 !== 7'd50 || err0 !== 1'b0) begin
         errors++;
         $display("FAIL err_4A done=%b bin=%0d err=%b expected 1 50 0", done0, bin0, err0);
      end
`endif
      cyc();
   endtask

   task automatic test_async_reset();
      bcd0 = 8'h63; start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      #2 reset = 1'b1;               // between edges, during CONV
      #1;
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || bin0 !== 7'd0 || err0 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset busy=%b done=%b bin=%0d err=%b expected 0 0 0 0", busy0, done0, bin0, err0);
      end
      cyc();
      #2 reset = 1'b0;
      cyc();
      cyc();
      cyc();
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || bin0 !== 7'd0) begin
         errors++;
         $display("FAIL reset_nodone done=%b busy=%b bin=%0d expected 0 0 0", done0, busy0, bin0);
      end
      bcd0 = 8'h12; start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      cyc();
      cyc();
      checks++;
      if (done0 !== 1'b1 || bin0 !== 7'd12 || err0 !== 1'b0) begin
         errors++;
         $display("FAIL after_reset done=%b bin=%0d err=%b expected 1 12 0", done0, bin0, err0);
      end
      cyc();
   endtask

   task automatic test_sweep3();
      for (int unsigned v = 0; v < 1000; v++) begin
         bcd1 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         start1 = 1'b1;
         cyc();
         start1 = 1'b0;
         cyc();
         cyc();
         cyc();
         checks++;
         if (done1 !== 1'b1 || bin1 !== 10'(v) || err1 !== 1'b0) begin
            errors++;
            $display("FAIL sweep3 bcd=%h done=%b bin=%0d err=%b expected 1 %0d 0", bcd1, done1, bin1, err1, v);
         end
         cyc();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      start0 = 1'b0;
      start1 = 1'b0;
      bcd0   = '0;
      bcd1   = '0;
      reset  = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_start_while_busy();
      test_err();
      test_async_reset();
      test_sweep3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
